// File: rtl/rsa_exp_ctrl_if.sv
// rtl/rsa_exp_ctrl_if.sv - handshake/strobe bundle between the RSA exponentiation sequencer and its datapath
//
// Purpose: groups the request, pre-processing, Montgomery-multiplier and status signals.
// master: the sequencer (drives strobes and status, receives start/key_e/pp_ready/mm_done).
// slave : the host/datapath side (drives start/key_e/pp_ready/mm_done, receives strobes).
interface rsa_exp_ctrl_if #(
  parameter int EXP_W = 256,
  parameter int IDX_W = 8
);
  logic             start;
  logic [EXP_W-1:0] key_e;
  logic             pp_ready;
  logic             mm_done;
  logic             pp_start;
  logic             t_load;
  logic             s_init;
  logic             mm_start;
  logic             mm_op;
  logic             s_we;
  logic             t_we;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_idx;

  modport master (
    input  start, key_e, pp_ready, mm_done,
    output pp_start, t_load, s_init, mm_start, mm_op, s_we, t_we, busy, done, bit_idx
  );

  modport slave (
    output start, key_e, pp_ready, mm_done,
    input  pp_start, t_load, s_init, mm_start, mm_op, s_we, t_we, busy, done, bit_idx
  );
endinterface

// File: rtl/rsa_exp_ctrl.sv
// rtl/rsa_exp_ctrl.sv - LSB-first square-and-multiply sequencer for the RSA modexp datapath
//
// Purpose: kicks pre-processing (T = M*R mod N), then for each exponent bit i issues
// S <= MM(S,T) when E[i]=1 and T <= MM(T,T) except after the last bit. S starts at 1,
// so S ends as M^E mod N. Only control strobes leave this block.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    rsa_exp_ctrl_if.master: start/key_e/pp_ready/mm_done in;
//          pp_start/t_load/s_init/mm_start/mm_op/s_we/t_we/busy/done/bit_idx out
module rsa_exp_ctrl #(
  parameter int EXP_W = 256,
  parameter int IDX_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rsa_exp_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE_START,
    ST_PRE_WAIT,
    ST_BIT,
    ST_MUL_START,
    ST_MUL_WAIT,
    ST_SQR_START,
    ST_SQR_WAIT,
    ST_DONE
  } state_t;

  state_t           state, state_nx;
  logic [EXP_W-1:0] e_reg, e_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             last_bit;
  logic             t_load, s_we, t_we;
  logic             pp_start_q, s_init_q, mm_start_q, mm_op_q, busy_q, done_q;

  assign last_bit = (idx == IDX_W'(EXP_W - 1));

  always_comb begin
    state_nx = state;
    e_nx     = e_reg;
    idx_nx   = idx;
    t_load   = 1'b0;
    s_we     = 1'b0;
    t_we     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          e_nx     = bus.key_e;
          idx_nx   = '0;
          state_nx = ST_PRE_START;
        end
      end
      ST_PRE_START: state_nx = ST_PRE_WAIT;
      ST_PRE_WAIT: begin
        if (bus.pp_ready) begin
          t_load   = 1'b1;
          state_nx = ST_BIT;
        end
      end
      ST_BIT: begin
        if (e_reg[0])      state_nx = ST_MUL_START;
        else if (last_bit) state_nx = ST_DONE;
        else               state_nx = ST_SQR_START;
      end
      ST_MUL_START: state_nx = ST_MUL_WAIT;
      ST_MUL_WAIT: begin
        if (bus.mm_done) begin
          s_we     = 1'b1;
          // The square after the top bit would be wasted work, so skip it.
          state_nx = last_bit ? ST_DONE : ST_SQR_START;
        end
      end
      ST_SQR_START: state_nx = ST_SQR_WAIT;
      ST_SQR_WAIT: begin
        if (bus.mm_done) begin
          t_we     = 1'b1;
          e_nx     = e_reg >> 1;
          idx_nx   = idx + IDX_W'(1);
          state_nx = ST_BIT;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each one is high exactly
  // while the FSM sits in the matching state, with no combinational glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      e_reg      <= '0;
      idx        <= '0;
      pp_start_q <= 1'b0;
      s_init_q   <= 1'b0;
      mm_start_q <= 1'b0;
      mm_op_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      e_reg      <= e_nx;
      idx        <= idx_nx;
      pp_start_q <= (state_nx == ST_PRE_START);
      s_init_q   <= (state_nx == ST_PRE_START);
      mm_start_q <= (state_nx == ST_MUL_START) || (state_nx == ST_SQR_START);
      mm_op_q    <= (state_nx == ST_SQR_START) || (state_nx == ST_SQR_WAIT);
      busy_q     <= (state_nx != ST_IDLE);
      done_q     <= (state_nx == ST_DONE);
    end
  end

  assign bus.pp_start = pp_start_q;
  assign bus.s_init   = s_init_q;
  assign bus.mm_start = mm_start_q;
  assign bus.mm_op    = mm_op_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.t_load   = t_load;
  assign bus.s_we     = s_we;
  assign bus.t_we     = t_we;
  assign bus.bit_idx  = idx;

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// tb/tb_rsa_exp_ctrl.sv - randomized self-checking bench for rsa_exp_ctrl with a modexp reference
`timescale 1ns/1ps
module tb_rsa_exp_ctrl;
  localparam int     SW = 4;
  localparam int     SI = 2;
  localparam int     BW = 256;
  localparam int     BI = 8;
  localparam longint N  = 197;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rsa_exp_ctrl_if #(.EXP_W(SW), .IDX_W(SI)) sif ();
  rsa_exp_ctrl_if #(.EXP_W(BW), .IDX_W(BI)) bif ();

  rsa_exp_ctrl #(.EXP_W(SW), .IDX_W(SI)) u_small (.clk(clk), .rst_n(rst_n), .bus(sif));
  rsa_exp_ctrl #(.EXP_W(BW), .IDX_W(BI)) u_big   (.clk(clk), .rst_n(rst_n), .bus(bif));

  int     n_checks = 0;
  int     n_pass   = 0;
  longint r_mod, r_inv;
  int     p_lat = 2;
  int     l_lat = 2;
  bit     spur_req = 1'b0;

  bit     s_ops[$];
  bit     s_wes[$];
  bit     exp_q[$];
  int     s_pp_cnt = 0, s_mm_cnt = 0, s_done = 0, s_err = 0, s_maxidx = 0;
  bit     s_spur_pend = 1'b0, s_out = 1'b0, s_lastop = 1'b0;
  longint s_m = 2, s_S = 0, s_T = 0;

  int     b_pp_cnt = 0, b_mm_cnt = 0, b_done = 0, b_muls = 0, b_ops = 0;
  longint b_m = 2, b_S = 0, b_T = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Montgomery product with R = 2^256 over the small modulus.
  function automatic longint mm(input longint a, input longint b);
    return (((a * b) % N) * r_inv) % N;
  endfunction

  function automatic longint modpow(input longint m, input logic [255:0] e);
    longint acc  = 1;
    longint base = m % N;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) acc = (acc * base) % N;
      base = (base * base) % N;
    end
    return acc;
  endfunction

  // Expected op order: per bit, multiply if set, then square unless it is the top bit.
  task automatic build_exp(input logic [255:0] e, input int w);
    exp_q.delete();
    for (int i = 0; i < w; i++) begin
      if (e[i]) exp_q.push_back(1'b0);
      if (i < w - 1) exp_q.push_back(1'b1);
    end
  endtask

  // Pre-processing and multiplier behaviour for the small instance.
  always @(negedge clk) begin
    sif.mm_done = 1'b0;
    if (!rst_n) begin
      s_pp_cnt = 0; s_mm_cnt = 0; s_spur_pend = 1'b0;
      sif.pp_ready = 1'b0;
    end else begin
      if (sif.pp_start) begin
        sif.pp_ready = 1'b0;
        s_pp_cnt = p_lat;
        if (spur_req) s_spur_pend = 1'b1;
      end else begin
        if (s_pp_cnt > 0) begin
          s_pp_cnt--;
          if (s_pp_cnt == 0) sif.pp_ready = 1'b1;
        end
        if (s_spur_pend) begin
          sif.mm_done = 1'b1;
          s_spur_pend = 1'b0;
        end
      end
      if (sif.mm_start) begin
        s_mm_cnt = l_lat;
        s_ops.push_back(sif.mm_op);
      end else if (s_mm_cnt > 0) begin
        s_mm_cnt--;
        if (s_mm_cnt == 0) sif.mm_done = 1'b1;
      end
    end
  end

  // Datapath model and protocol monitor for the small instance.
  always @(negedge clk) begin
    #2;
    if (!rst_n) s_out = 1'b0;
    else begin
      if (sif.s_init) s_S = 1;
      if (sif.t_load) s_T = (s_m * r_mod) % N;
      if (sif.mm_start) begin
        if (s_out) s_err++;
        s_out = 1'b1;
        s_lastop = sif.mm_op;
      end
      if (sif.mm_done && s_out && (sif.mm_op != s_lastop)) s_err++;
      if (sif.s_we && sif.t_we) s_err++;
      if (sif.s_we) begin s_wes.push_back(1'b0); s_S = mm(s_S, s_T); s_out = 1'b0; end
      if (sif.t_we) begin s_wes.push_back(1'b1); s_T = mm(s_T, s_T); s_out = 1'b0; end
      if (sif.done) s_done++;
      if (int'(sif.bit_idx) > s_maxidx) s_maxidx = int'(sif.bit_idx);
    end
  end

  // Responder for the wide instance.
  always @(negedge clk) begin
    bif.mm_done = 1'b0;
    if (!rst_n) begin
      b_pp_cnt = 0; b_mm_cnt = 0;
      bif.pp_ready = 1'b0;
    end else begin
      if (bif.pp_start) begin
        bif.pp_ready = 1'b0;
        b_pp_cnt = p_lat;
      end else if (b_pp_cnt > 0) begin
        b_pp_cnt--;
        if (b_pp_cnt == 0) bif.pp_ready = 1'b1;
      end
      if (bif.mm_start) begin
        b_mm_cnt = l_lat;
        b_ops++;
        if (!bif.mm_op) b_muls++;
      end else if (b_mm_cnt > 0) begin
        b_mm_cnt--;
        if (b_mm_cnt == 0) bif.mm_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (bif.s_init) b_S = 1;
      if (bif.t_load) b_T = (b_m * r_mod) % N;
      if (bif.s_we) b_S = mm(b_S, b_T);
      if (bif.t_we) b_T = mm(b_T, b_T);
      if (bif.done) b_done++;
    end
  end

  task automatic run_small(input logic [3:0] e, input bit poke, input bit spur, input string tag);
    bit seen = 1'b0;
    int poke_st = 0;
    @(negedge clk);
    s_ops.delete(); s_wes.delete();
    s_done = 0; s_err = 0; s_maxidx = 0;
    s_m = longint'($urandom_range(2, 196));
    p_lat = int'($urandom_range(1, 4));
    l_lat = int'($urandom_range(1, 5));
    spur_req = spur;
    sif.key_e = e;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    sif.key_e = '1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk); #3;
      if (poke) begin
        if (poke_st == 2) begin sif.start = 1'b0; poke_st = 3; end
        else if (poke_st == 1) begin sif.start = 1'b1; poke_st = 2; end
        else if (poke_st == 0 && sif.mm_start && !sif.mm_op) poke_st = 1;
      end
      if (s_done > 0) begin seen = 1'b1; break; end
    end
    sif.start = 1'b0;
    spur_req = 1'b0;
    check({tag, "_done_seen"}, longint'(seen), 1);
    check({tag, "_busy_in_done"}, longint'(sif.busy), 1);
    @(negedge clk); #3;
    check({tag, "_busy_after"}, longint'(sif.busy), 0);
    @(negedge clk); #3;
    check({tag, "_still_idle"}, longint'(sif.busy), 0);
    build_exp({252'b0, e}, SW);
    check({tag, "_op_count"}, s_ops.size(), exp_q.size());
    check({tag, "_we_count"}, s_wes.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < s_ops.size()) check($sformatf("%s_op%0d", tag, i), longint'(s_ops[i]), longint'(exp_q[i]));
      if (i < s_wes.size()) check($sformatf("%s_we%0d", tag, i), longint'(s_wes[i]), longint'(exp_q[i]));
    end
    check({tag, "_done_pulses"}, s_done, 1);
    check({tag, "_protocol_errs"}, s_err, 0);
    check({tag, "_max_idx"}, s_maxidx, SW - 1);
    check({tag, "_result"}, s_S, modpow(s_m, {252'b0, e}));
  endtask

  initial begin
    bit seen;
    r_mod = 1;
    for (int i = 0; i < 256; i++) r_mod = (r_mod * 2) % N;
    r_inv = 0;
    for (longint x = 1; x < N; x++) if ((r_mod * x) % N == 1) r_inv = x;
    sif.start = 1'b0; sif.key_e = '0;
    bif.start = 1'b0; bif.key_e = '0;

    repeat (3) @(negedge clk);
    #3;
    check("rst_busy", longint'(sif.busy), 0);
    check("rst_pp_start", longint'(sif.pp_start), 0);
    check("rst_mm_start", longint'(sif.mm_start), 0);
    check("rst_mm_op", longint'(sif.mm_op), 0);
    check("rst_done", longint'(sif.done), 0);
    check("rst_bit_idx", longint'(sif.bit_idx), 0);
    check("rst_big_busy", longint'(bif.busy), 0);
    rst_n = 1'b1;

    run_small(4'b0101, 1'b0, 1'b0, "e0101");
    run_small(4'b0000, 1'b0, 1'b0, "e0000");
    run_small(4'b1111, 1'b0, 1'b0, "e1111");
    for (int k = 0; k < 6; k++) run_small(4'($urandom), 1'b0, 1'b0, $sformatf("rnd%0d", k));
    run_small(4'b1011, 1'b1, 1'b1, "poke");

    // Abort a run while a square is outstanding.
    @(negedge clk);
    p_lat = 2; l_lat = 3;
    sif.key_e = 4'b0110;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk); #3;
      if (sif.mm_start && sif.mm_op) begin seen = 1'b1; break; end
    end
    check("abort_sqr_seen", longint'(seen), 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #3;
    check("abort_busy", longint'(sif.busy), 0);
    check("abort_pp_start", longint'(sif.pp_start), 0);
    check("abort_s_init", longint'(sif.s_init), 0);
    check("abort_t_load", longint'(sif.t_load), 0);
    check("abort_mm_start", longint'(sif.mm_start), 0);
    check("abort_mm_op", longint'(sif.mm_op), 0);
    check("abort_s_we", longint'(sif.s_we), 0);
    check("abort_t_we", longint'(sif.t_we), 0);
    check("abort_done", longint'(sif.done), 0);
    check("abort_bit_idx", longint'(sif.bit_idx), 0);
    rst_n = 1'b1;
    run_small(4'b0110, 1'b0, 1'b0, "after_abort");

    // Full-width run with the Montgomery datapath model.
    @(negedge clk);
    b_m = 17; b_done = 0; b_ops = 0; b_muls = 0;
    p_lat = int'($urandom_range(1, 4));
    l_lat = int'($urandom_range(1, 5));
    bif.key_e = 256'h3;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    bif.key_e = '0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk); #3;
      if (b_done > 0) begin seen = 1'b1; break; end
    end
    check("big_done_seen", longint'(seen), 1);
    check("big_result", b_S, modpow(17, 256'h3));
    @(negedge clk); #3;
    check("big_busy_after", longint'(bif.busy), 0);
    check("big_ops", b_ops, 2 + BW - 1);
    check("big_muls", b_muls, 2);
    check("big_done_pulses", b_done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
